produto_escalar_param: RTL and testbench

Parametrised dot-product engine: N-element vectors of DATA_W-bit operands, LANES multiply-accumulates per cycle, run-time signed/unsigned selection. It snapshots both vectors on a start edge and accumulates into a widened, overflow-free accumulator. It adds abort and busy status. It is the general-purpose successor of the fixed 8×32-bit scalar-product unit and sits behind the same CSR-mapped SoC peripheral wrapper.

---
 rtl/produto_escalar_param.sv | 167 ++++++++++++++++
 tb/tb_produto_escalar_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/produto_escalar_param.sv
// produto_escalar_param
// Parametrised dot-product engine. It snapshots both operand vectors on a
// rising edge of iniciar, then accumulates LANES products per cycle into a
// widened accumulator. The final value goes to resultado and is held there.
// Each operand is extended by one bit (sign or zero), so a single signed
// multiplier path serves both signed and unsigned modes.

module produto_escalar_param #(
  parameter int DATA_W = 32,
  parameter int N      = 8,
  parameter int LANES  = 1,
  parameter int ACC_W  = 2*DATA_W + $clog2(N) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                iniciar,
  input  logic                abortar,
  input  logic                modo_signed,
  input  logic [N*DATA_W-1:0] a_i,
  input  logic [N*DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]    resultado,
  output logic                concluido,
  output logic                ocupado
);

  localparam int K      = N / LANES;
  localparam int CNT_W  = (K > 1) ? $clog2(K) : 1;
  localparam int PROD_W = 2*DATA_W + 2;
  localparam int VEC_W  = N*DATA_W;

  // Reject parameter sets the datapath cannot honour.
  if (N % LANES != 0) begin : g_bad_lanes
    $error("produto_escalar_param: N must be a multiple of LANES");
  end
  if (DATA_W < 2) begin : g_bad_width
    $error("produto_escalar_param: DATA_W must be at least 2");
  end
  if (N < 1) begin : g_bad_len
    $error("produto_escalar_param: N must be at least 1");
  end

  typedef enum logic [1:0] {
    PARADO     = 2'd0,
    CALCULANDO = 2'd1,
    CONCLUIDO  = 2'd2
  } estado_t;

  estado_t              state_r, state_n;
  logic                 iniciar_prev_r;
  logic                 start_pulse_s;
  logic                 start_ok_s;
  logic                 last_beat_s;
  logic [VEC_W-1:0]     a_lat_r, b_lat_r;
  logic                 signed_lat_r;
  logic [CNT_W-1:0]     contador_r;
  logic [ACC_W-1:0]     acumulador_r;
  logic [ACC_W-1:0]     beat_sum_s;
  logic [ACC_W-1:0]     acc_next_s;
  logic [ACC_W-1:0]     resultado_r;
  logic                 concluido_r, ocupado_r;

  // One product term. The operands are extended to DATA_W+1 bits and then
  // multiplied as signed values. The result is sign-extended to ACC_W. In
  // unsigned mode the product is never negative, so sign extension equals
  // zero extension.
  function automatic logic [ACC_W-1:0] mac_term(
    input logic [DATA_W-1:0] op_a,
    input logic [DATA_W-1:0] op_b,
    input logic              sgn
  );
    logic signed [PROD_W-1:0] ea;
    logic signed [PROD_W-1:0] eb;
    logic signed [PROD_W-1:0] prod;
    ea   = PROD_W'($signed({sgn & op_a[DATA_W-1], op_a}));
    eb   = PROD_W'($signed({sgn & op_b[DATA_W-1], op_b}));
    prod = ea * eb;
    return ACC_W'(prod);
  endfunction

  assign start_pulse_s = iniciar & ~iniciar_prev_r;
  assign start_ok_s    = start_pulse_s & (state_r != CALCULANDO);
  assign last_beat_s   = (contador_r == CNT_W'(K - 1));
  assign acc_next_s    = acumulador_r + beat_sum_s;

  // Sum of this beat's LANES products taken from the latched operands.
  always_comb begin
    beat_sum_s = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum_s = beat_sum_s + mac_term(
        a_lat_r[(int'(contador_r)*LANES + l)*DATA_W +: DATA_W],
        b_lat_r[(int'(contador_r)*LANES + l)*DATA_W +: DATA_W],
        signed_lat_r);
    end
  end

  // Next-state logic. An abort overrides completion. Start edges count only
  // outside CALCULANDO.
  always_comb begin
    state_n = state_r;
    case (state_r)
      PARADO: begin
        if (start_ok_s) state_n = CALCULANDO;
        else            state_n = PARADO;
      end
      CALCULANDO: begin
        if (abortar)          state_n = PARADO;
        else if (last_beat_s) state_n = CONCLUIDO;
        else                  state_n = CALCULANDO;
      end
      CONCLUIDO: begin
        if (start_ok_s) state_n = CALCULANDO;
        else            state_n = CONCLUIDO;
      end
      default: state_n = PARADO;
    endcase
  end

  // State register, start-edge history and registered status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r        <= PARADO;
      iniciar_prev_r <= 1'b0;
      concluido_r    <= 1'b0;
      ocupado_r      <= 1'b0;
    end else begin
      state_r        <= state_n;
      iniciar_prev_r <= iniciar;
      concluido_r    <= (state_n == CONCLUIDO);
      ocupado_r      <= (state_n == CALCULANDO);
    end
  end

  // Datapath: operand snapshot, accumulation and capture of the result.
  // An abort leaves resultado untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_lat_r      <= '0;
      b_lat_r      <= '0;
      signed_lat_r <= 1'b0;
      contador_r   <= '0;
      acumulador_r <= '0;
      resultado_r  <= '0;
    end else if (start_ok_s) begin
      a_lat_r      <= a_i;
      b_lat_r      <= b_i;
      signed_lat_r <= modo_signed;
      contador_r   <= '0;
      acumulador_r <= '0;
    end else if ((state_r == CALCULANDO) && !abortar) begin
      acumulador_r <= acc_next_s;
      if (last_beat_s) begin
        contador_r  <= '0;
        resultado_r <= acc_next_s;
      end else begin
        contador_r  <= contador_r + CNT_W'(1);
      end
    end else begin
      contador_r   <= contador_r;
      acumulador_r <= acumulador_r;
    end
  end

  assign resultado = resultado_r;
  assign concluido = concluido_r;
  assign ocupado   = ocupado_r;

endmodule

// File: tb/tb_produto_escalar_param.sv
// Directed bench for produto_escalar_param. u_dut uses the default
// parameters (N=8, LANES=1). u_dut4 uses LANES=4. Both share all inputs.
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.

module tb_produto_escalar_param;

  localparam int ACC_W = 68;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             iniciar;
  logic             abortar;
  logic             modo_signed;
  logic [255:0]     a_i;
  logic [255:0]     b_i;
  logic [ACC_W-1:0] resultado, resultado4;
  logic             concluido, concluido4;
  logic             ocupado, ocupado4;

  int n_vec = 0;
  int n_err = 0;
  int lat, busy, lat4, rises;
  logic prev_c;

  produto_escalar_param u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .iniciar(iniciar), .abortar(abortar),
    .modo_signed(modo_signed), .a_i(a_i), .b_i(b_i),
    .resultado(resultado), .concluido(concluido), .ocupado(ocupado)
  );

  produto_escalar_param #(.LANES(4)) u_dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .iniciar(iniciar), .abortar(abortar),
    .modo_signed(modo_signed), .a_i(a_i), .b_i(b_i),
    .resultado(resultado4), .concluido(concluido4), .ocupado(ocupado4)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [ACC_W-1:0] obs,
                       input logic [ACC_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pulse iniciar for one edge (E0), then wait for completion with a bound.
  task automatic do_run(output int l, output int b, output int l4);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    l  = 0;
    l4 = 0;
    b  = ocupado ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      l++;
      if (ocupado) b++;
      if (concluido4 && l4 == 0) l4 = l;
      if (concluido) break;
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    iniciar     = 1'b0;
    abortar     = 1'b0;
    modo_signed = 1'b0;
    a_i         = '0;
    b_i         = '0;

    // Reset state
    tick(); tick();
    check("rst_resultado", resultado, 68'd0);
    check("rst_concluido", ACC_W'(concluido), 68'd0);
    check("rst_ocupado",   ACC_W'(ocupado),   68'd0);
    rst_ni = 1'b1;
    tick();

    // Basic sum: a=1..8, b=1, unsigned
    for (int i = 0; i < 8; i++) begin
      a_i[i*32 +: 32] = 32'(i + 1);
      b_i[i*32 +: 32] = 32'd1;
    end
    do_run(lat, busy, lat4);
    check("basic_resultado", resultado, 68'd36);
    check("basic_latency",   ACC_W'(lat),  68'd8);
    check("basic_busy",      ACC_W'(busy), 68'd8);

    // Restart from CONCLUIDO, then abort at beat 4
    tick();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("restart_concluido", ACC_W'(concluido), 68'd0);
    check("restart_ocupado",   ACC_W'(ocupado),   68'd1);
    check("restart_keep_res",  resultado,         68'd36);
    tick(); tick(); tick();
    abortar = 1'b1;
    tick();
    abortar = 1'b0;
    check("abort_ocupado",   ACC_W'(ocupado),   68'd0);
    check("abort_concluido", ACC_W'(concluido), 68'd0);
    check("abort_resultado", resultado,         68'd36);
    tick(); tick();
    check("abort_idle_concluido", ACC_W'(concluido), 68'd0);

    // Signed: a = all 0xFFFFFFFF, b = all 2 -> -16
    for (int i = 0; i < 8; i++) begin
      a_i[i*32 +: 32] = 32'hFFFF_FFFF;
      b_i[i*32 +: 32] = 32'd2;
    end
    modo_signed = 1'b1;
    do_run(lat, busy, lat4);
    check("signed_neg16", resultado, 68'hF_FFFF_FFFF_FFFF_FFF0);

    // Same operands, unsigned
    modo_signed = 1'b0;
    tick();
    do_run(lat, busy, lat4);
    check("unsigned_big", resultado, 68'h0_0000_000F_FFFF_FFF0);

    // Extreme signed: all 0x80000000 -> 2^65
    for (int i = 0; i < 8; i++) begin
      a_i[i*32 +: 32] = 32'h8000_0000;
      b_i[i*32 +: 32] = 32'h8000_0000;
    end
    modo_signed = 1'b1;
    tick();
    do_run(lat, busy, lat4);
    check("extreme_signed", resultado, 68'h2_0000_0000_0000_0000);

    // LANES=4 vs LANES=1: a=1..8, b=8..1 -> 120
    for (int i = 0; i < 8; i++) begin
      a_i[i*32 +: 32] = 32'(i + 1);
      b_i[i*32 +: 32] = 32'(8 - i);
    end
    modo_signed = 1'b0;
    tick();
    do_run(lat, busy, lat4);
    check("lanes4_latency",  ACC_W'(lat4), 68'd2);
    check("lanes4_result",   resultado4,   68'd120);
    check("lanes1_result",   resultado,    68'd120);

    // Snapshot and ignore: a changes mid-run, a second start edge comes in
    for (int i = 0; i < 8; i++) begin
      a_i[i*32 +: 32] = 32'(i + 1);
      b_i[i*32 +: 32] = 32'd1;
    end
    tick();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    rises  = 0;
    prev_c = concluido;
    tick(); tick();
    for (int i = 0; i < 8; i++) a_i[i*32 +: 32] = 32'd100;
    modo_signed = 1'b1;
    iniciar     = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      iniciar = 1'b0;
      if (concluido && !prev_c) rises++;
      prev_c = concluido;
    end
    check("snap_resultado",  resultado,        68'd36);
    check("snap_completions", ACC_W'(rises),   68'd1);
    check("snap_ocupado",    ACC_W'(ocupado),  68'd0);

    // Asynchronous reset in the middle of a calculation
    modo_signed = 1'b0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_resultado", resultado,         68'd0);
    check("arst_concluido", ACC_W'(concluido), 68'd0);
    check("arst_ocupado",   ACC_W'(ocupado),   68'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
